fwd_select_unit: RTL and testbench
==================================

Name: fwd_select_unit

Overview:
- Control-side counterpart to the 32-bit 3-way operand select mux in the EX stage. Produces the 2-bit SELECT codes for the rs1 and rs2 operand muxes and the load-use stall.
- Select encoding: 00 = register-file value, 01 = EX/MEM result (INPUT2), 10 = MEM/WB result (INPUT3).
- Tracks destination registers of the instructions in flight in EX, MEM and WB in its own shadow pipeline.
- Sits beside the ID/EX pipeline register and is clocked with it.

Parameters:
- REG_ADDR_W, 5, register address width.
- CNT_W, 16, statistics counter width (used only with FWD_STATS_EN).

Ports:
- CLK  input  1  pipeline clock, all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- ID_VALID  input  1  ID stage holds a real instruction.
- ID_RS1  input  REG_ADDR_W  source register 1 of the ID instruction.
- ID_RS2  input  REG_ADDR_W  source register 2 of the ID instruction.
- ID_RD  input  REG_ADDR_W  destination register of the ID instruction.
- ID_REG_WRITE  input  1  ID instruction writes ID_RD.
- ID_MEM_READ  input  1  ID instruction is a load.
- FLUSH  input  1  branch taken; the ID instruction must not enter EX.
- FWD_A_SEL  output  2  registered select code for the rs1 operand mux.
- FWD_B_SEL  output  2  registered select code for the rs2 operand mux.
- STALL  output  1  combinational load-use stall; holds PC and IF/ID.
- STALL_CNT  output  CNT_W  stall cycle count (FWD_STATS_EN only).
- FWD_CNT  output  CNT_W  forwarded-operand count (FWD_STATS_EN only).

Behaviour:
- Shadow slots:
  - EX slot: valid, rd, wr, load.
  - MEM slot: valid, rd, wr.
  - WB is not tracked. The register file writes before it reads, so a WB-stage producer needs no forwarding.
- RESET high at an edge:
  - All slots invalid.
  - FWD_A_SEL = FWD_B_SEL = 2'b00.
  - STALL = 0.
  - Counters = 0.
  - RESET applied mid-stream discards all in-flight tracking.
- A slot "writes r" only if valid && wr && rd == r && r != 0. x0 never forwards.
- STALL:
  - STALL = EX.valid && EX.load && EX.wr && EX.rd != 0 && ID_VALID && (ID_RS1 == EX.rd || ID_RS2 == EX.rd) && !FLUSH.
  - Purely combinational from current slots and ID inputs. It is a one-cycle stall by construction.
- Each rising edge (RESET low):
  - MEM slot <= EX slot, always, including during a stall.
  - If FLUSH or STALL or !ID_VALID: EX slot <= bubble (valid = 0), and FWD_A_SEL, FWD_B_SEL <= 00.
  - Otherwise: EX slot <= {1, ID_RD, ID_REG_WRITE, ID_MEM_READ}.
  - Otherwise, per operand (rs = ID_RS1 for A, ID_RS2 for B): if the current EX slot writes rs, SEL <= 01; else if the current MEM slot writes rs, SEL <= 10; else SEL <= 00.
  - The EX slot has priority because it holds the youngest producer.
- Latency: select codes become valid one edge after the consumer is presented in ID, aligned with the consumer entering EX.
- Load-use sequence:
  - Cycle t: load in EX, dependent consumer in ID, STALL = 1.
  - Cycle t+1: load in MEM, bubble in EX, consumer still in ID, STALL = 0.
  - Cycle t+2: consumer in EX, SEL = 10.
- Code 2'b11 is never produced. The downstream mux latches on 11, so emitting it is a functional bug.
- FLUSH and STALL in the same cycle: FLUSH wins and STALL is forced to 0.
- Both operands may select independently, including the same source.

Optional Feature:
- FWD_STATS_EN defined:
  - STALL_CNT increments on each cycle with STALL = 1.
  - FWD_CNT adds the number of operands (0, 1 or 2) given a non-00 SEL at each edge.
  - Both counters saturate at all-ones and clear on RESET.
- FWD_STATS_EN undefined: counters, their logic and both ports are absent.

Test Plan:
- RESET held 2 cycles mid-stream with slots populated -> SELs 00, STALL 0, next ID instruction rs1 = old rd gets SEL 00.
- Present add x5 (wr), then sub rs1 = x5 -> at sub's EX edge FWD_A_SEL = 01, FWD_B_SEL = 00.
- Present add x5, an independent instruction, then or rs2 = x5 -> FWD_B_SEL = 10.
- Present lw x7, then add rs1 = x7, rs2 = x7 -> STALL = 1 exactly one cycle; next edge SELs 00 (bubble); following edge both SEL = 10; STALL_CNT = 1, FWD_CNT = 2 under FWD_STATS_EN.
- Producer writes x0, consumer rs1 = x0 -> SEL 00; producers to x3 in both EX and MEM, consumer rs1 = x3 -> SEL 01.
- lw x7 in EX, consumer rs1 = x7 with FLUSH = 1 -> STALL = 0, EX bubble, SELs 00; over 1000 random cycles SEL never equals 11.

Source files
------------

// File: rtl/fwd_select_unit.sv
// fwd_select_unit: operand-forwarding select and load-use stall control for the
// EX stage. It tracks the EX and MEM producers in a shadow pipeline that is
// clocked alongside the ID/EX register.
// Select codes: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result.
// Optional build macro FWD_STATS_EN adds the saturating STALL_CNT and FWD_CNT
// statistics counters and their ports.
module fwd_select_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ID_VALID,
  input  logic [REG_ADDR_W-1:0] ID_RS1,
  input  logic [REG_ADDR_W-1:0] ID_RS2,
  input  logic [REG_ADDR_W-1:0] ID_RD,
  input  logic                  ID_REG_WRITE,
  input  logic                  ID_MEM_READ,
  input  logic                  FLUSH,
  output logic [1:0]            FWD_A_SEL,
  output logic [1:0]            FWD_B_SEL,
  output logic                  STALL
`ifdef FWD_STATS_EN
  ,
  output logic [CNT_W-1:0]      STALL_CNT,
  output logic [CNT_W-1:0]      FWD_CNT
`endif
);

  typedef enum logic [1:0] {
    SEL_RF    = 2'b00,
    SEL_EXMEM = 2'b01,
    SEL_MEMWB = 2'b10
  } sel_e;

  // EX shadow slot
  logic                  ex_v_q, ex_v_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic                  ex_wr_q, ex_wr_d;
  logic                  ex_ld_q, ex_ld_d;
  // MEM shadow slot
  logic                  mem_v_q, mem_v_d;
  logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
  logic                  mem_wr_q, mem_wr_d;
  // Registered select codes
  sel_e                  sel_a_q, sel_a_d;
  sel_e                  sel_b_q, sel_b_d;

  logic a_from_ex, a_from_mem, b_from_ex, b_from_mem;
  logic advance;

  // A slot forwards only for a valid, writing producer whose rd matches a non-x0 source
  always_comb begin
    a_from_ex  = ex_v_q  && ex_wr_q  && (ex_rd_q  == ID_RS1) && (ID_RS1 != '0);
    a_from_mem = mem_v_q && mem_wr_q && (mem_rd_q == ID_RS1) && (ID_RS1 != '0);
    b_from_ex  = ex_v_q  && ex_wr_q  && (ex_rd_q  == ID_RS2) && (ID_RS2 != '0);
    b_from_mem = mem_v_q && mem_wr_q && (mem_rd_q == ID_RS2) && (ID_RS2 != '0);
  end

  // Load-use stall: the load result is not available until MEM/WB; FLUSH overrides it
  always_comb begin
    STALL = ex_v_q && ex_ld_q && ex_wr_q && (ex_rd_q != '0) && ID_VALID &&
            ((ID_RS1 == ex_rd_q) || (ID_RS2 == ex_rd_q)) && !FLUSH;
  end

  // Next state: MEM always follows EX; EX takes the ID instruction or a bubble.
  // The EX producer is checked first because it is the youngest writer of rs.
  always_comb begin
    advance  = ID_VALID && !FLUSH && !STALL;
    mem_v_d  = ex_v_q;
    mem_rd_d = ex_rd_q;
    mem_wr_d = ex_wr_q;
    ex_v_d   = 1'b0;
    ex_rd_d  = '0;
    ex_wr_d  = 1'b0;
    ex_ld_d  = 1'b0;
    sel_a_d  = SEL_RF;
    sel_b_d  = SEL_RF;
    if (advance) begin
      ex_v_d  = 1'b1;
      ex_rd_d = ID_RD;
      ex_wr_d = ID_REG_WRITE;
      ex_ld_d = ID_MEM_READ;
      if (a_from_ex)       sel_a_d = SEL_EXMEM;
      else if (a_from_mem) sel_a_d = SEL_MEMWB;
      if (b_from_ex)       sel_b_d = SEL_EXMEM;
      else if (b_from_mem) sel_b_d = SEL_MEMWB;
    end
  end

  // Shadow pipeline and select registers; reset discards all in-flight tracking
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ex_v_q   <= 1'b0;
      ex_rd_q  <= '0;
      ex_wr_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      mem_v_q  <= 1'b0;
      mem_rd_q <= '0;
      mem_wr_q <= 1'b0;
      sel_a_q  <= SEL_RF;
      sel_b_q  <= SEL_RF;
    end else begin
      ex_v_q   <= ex_v_d;
      ex_rd_q  <= ex_rd_d;
      ex_wr_q  <= ex_wr_d;
      ex_ld_q  <= ex_ld_d;
      mem_v_q  <= mem_v_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      sel_a_q  <= sel_a_d;
      sel_b_q  <= sel_b_d;
    end
  end

  assign FWD_A_SEL = sel_a_q;
  assign FWD_B_SEL = sel_b_q;

`ifdef FWD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
  logic [1:0]       fwd_inc;
  logic [CNT_W:0]   fwd_sum;

  // Saturating statistics: stall cycles and operands forwarded per edge (0..2)
  always_comb begin
    fwd_inc     = {1'b0, sel_a_d != SEL_RF} + {1'b0, sel_b_d != SEL_RF};
    fwd_sum     = {1'b0, fwd_cnt_q} + (CNT_W+1)'(fwd_inc);
    fwd_cnt_d   = fwd_sum[CNT_W] ? '1 : fwd_sum[CNT_W-1:0];
    stall_cnt_d = stall_cnt_q;
    if (STALL && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // Counter registers, cleared by reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign STALL_CNT = stall_cnt_q;
  assign FWD_CNT   = fwd_cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W == 0);
`endif

endmodule

// File: tb/tb_fwd_select_unit.sv
// Directed bench for fwd_select_unit: table of ID instructions with
// hand-computed select/stall expectations, a mid-stream reset sequence, and a
// random sweep checking that code 11 never appears and FLUSH suppresses STALL.
module tb_fwd_select_unit;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       ID_VALID;
  logic [4:0] ID_RS1, ID_RS2, ID_RD;
  logic       ID_REG_WRITE, ID_MEM_READ, FLUSH;
  logic [1:0] FWD_A_SEL, FWD_B_SEL;
  logic       STALL;
`ifdef FWD_STATS_EN
  logic [15:0] STALL_CNT, FWD_CNT;
  logic [15:0] stall_base, fwd_base;
`endif

  int total = 0;
  int bad   = 0;

  fwd_select_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ID_VALID     (ID_VALID),
    .ID_RS1       (ID_RS1),
    .ID_RS2       (ID_RS2),
    .ID_RD        (ID_RD),
    .ID_REG_WRITE (ID_REG_WRITE),
    .ID_MEM_READ  (ID_MEM_READ),
    .FLUSH        (FLUSH),
    .FWD_A_SEL    (FWD_A_SEL),
    .FWD_B_SEL    (FWD_B_SEL),
    .STALL        (STALL)
`ifdef FWD_STATS_EN
    ,
    .STALL_CNT    (STALL_CNT),
    .FWD_CNT      (FWD_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       fl;
    logic       xs;   // expected STALL before the edge
    logic [1:0] xa;   // expected FWD_A_SEL after the edge
    logic [1:0] xb;   // expected FWD_B_SEL after the edge
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    ID_VALID     = t.v;
    ID_RS1       = t.rs1;
    ID_RS2       = t.rs2;
    ID_RD        = t.rd;
    ID_REG_WRITE = t.wr;
    ID_MEM_READ  = t.ld;
    FLUSH        = t.fl;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b1;
    drive('0);
    tick();
    tick();
    check("reset_sel_a", 0, 32'(FWD_A_SEL), 0);
    check("reset_sel_b", 0, 32'(FWD_B_SEL), 0);
    check("reset_stall", 0, 32'(STALL), 0);
`ifdef FWD_STATS_EN
    check("reset_stall_cnt", 0, 32'(STALL_CNT), 0);
    check("reset_fwd_cnt", 0, 32'(FWD_CNT), 0);
`endif
    RESET = 1'b0;

    //                 v  rs1 rs2  rd wr ld fl xs  xa     xb
    vecs.push_back('{1, 1,  2,  5, 1, 0, 0, 0, 2'b00, 2'b00}); // 0 add x5
    vecs.push_back('{1, 5,  3,  6, 1, 0, 0, 0, 2'b01, 2'b00}); // 1 sub rs1=x5 (EX)
    vecs.push_back('{1, 1,  2,  5, 1, 0, 0, 0, 2'b00, 2'b00}); // 2 add x5
    vecs.push_back('{1, 1,  2,  8, 1, 0, 0, 0, 2'b00, 2'b00}); // 3 independent
    vecs.push_back('{1, 4,  5,  9, 1, 0, 0, 0, 2'b00, 2'b10}); // 4 or rs2=x5 (MEM)
    vecs.push_back('{1, 1,  0,  7, 1, 1, 0, 0, 2'b00, 2'b00}); // 5 lw x7
    vecs.push_back('{1, 7,  7, 10, 1, 0, 0, 1, 2'b00, 2'b00}); // 6 add x7,x7 stalls
    vecs.push_back('{1, 7,  7, 10, 1, 0, 0, 0, 2'b10, 2'b10}); // 7 add x7,x7 proceeds
    vecs.push_back('{1, 1,  2,  0, 1, 0, 0, 0, 2'b00, 2'b00}); // 8 writes x0
    vecs.push_back('{1, 0,  0, 11, 1, 0, 0, 0, 2'b00, 2'b00}); // 9 reads x0
    vecs.push_back('{1, 1,  2,  3, 1, 0, 0, 0, 2'b00, 2'b00}); // 10 x3
    vecs.push_back('{1, 1,  2,  3, 1, 0, 0, 0, 2'b00, 2'b00}); // 11 x3 again
    vecs.push_back('{1, 3,  3, 12, 1, 0, 0, 0, 2'b01, 2'b01}); // 12 x3 in EX and MEM
    vecs.push_back('{1, 1,  2,  7, 1, 1, 0, 0, 2'b00, 2'b00}); // 13 lw x7
    vecs.push_back('{1, 7,  0, 13, 1, 0, 1, 0, 2'b00, 2'b00}); // 14 flushed dependent
    vecs.push_back('{1, 7,  0, 14, 1, 0, 0, 0, 2'b10, 2'b00}); // 15 EX bubble, lw in MEM
    vecs.push_back('{0, 7,  7,  0, 0, 0, 0, 0, 2'b00, 2'b00}); // 16 ID invalid
    vecs.push_back('{1, 14, 0, 15, 1, 0, 0, 0, 2'b10, 2'b00}); // 17 x14 now in MEM
    vecs.push_back('{1, 1,  2, 20, 0, 0, 0, 0, 2'b00, 2'b00}); // 18 non-writing rd=x20
    vecs.push_back('{1, 20, 20, 21, 1, 0, 0, 0, 2'b00, 2'b00}); // 19 no forward from wr=0
    vecs.push_back('{1, 1,  2, 22, 1, 1, 0, 0, 2'b00, 2'b00}); // 20 lw x22

    foreach (vecs[i]) begin
`ifdef FWD_STATS_EN
      if (i == 5) begin
        stall_base = STALL_CNT;
        fwd_base   = FWD_CNT;
      end
`endif
      drive(vecs[i]);
      #1;
      check("stall", i, 32'(STALL), 32'(vecs[i].xs));
      tick();
      check("sel_a", i, 32'(FWD_A_SEL), 32'(vecs[i].xa));
      check("sel_b", i, 32'(FWD_B_SEL), 32'(vecs[i].xb));
`ifdef FWD_STATS_EN
      if (i == 7) begin
        check("stall_cnt_delta", i, 32'(STALL_CNT - stall_base), 1);
        check("fwd_cnt_delta", i, 32'(FWD_CNT - fwd_base), 2);
      end
`endif
    end

    // Mid-stream reset: lw x22 sits in EX, a dependent is waiting in ID.
    drive('{1, 22, 0, 23, 1, 0, 0, 0, 2'b00, 2'b00});
    #1;
    check("pre_reset_stall", 0, 32'(STALL), 1);
    RESET = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("mid_reset_sel_a", k, 32'(FWD_A_SEL), 0);
      check("mid_reset_sel_b", k, 32'(FWD_B_SEL), 0);
      check("mid_reset_stall", k, 32'(STALL), 0);
    end
    RESET = 1'b0;
    tick();
    check("post_reset_sel_a", 0, 32'(FWD_A_SEL), 0);
    check("post_reset_sel_b", 0, 32'(FWD_B_SEL), 0);

    // Random sweep over a small register range to provoke many hazards.
    for (int c = 0; c < 1000; c++) begin
      ID_VALID     = ($urandom_range(0, 7) != 0);
      ID_RS1       = 5'($urandom_range(0, 3));
      ID_RS2       = 5'($urandom_range(0, 3));
      ID_RD        = 5'($urandom_range(0, 3));
      ID_REG_WRITE = ($urandom_range(0, 3) != 0);
      ID_MEM_READ  = ($urandom_range(0, 2) == 0);
      FLUSH        = ($urandom_range(0, 7) == 0);
      #1;
      if (FLUSH) check("flush_kills_stall", c, 32'(STALL), 0);
      tick();
      total++;
      if (FWD_A_SEL == 2'b11 || FWD_B_SEL == 2'b11) begin
        bad++;
        $display("FAIL sel_not_11[%0d]: got a=%b b=%b required neither 11", c, FWD_A_SEL, FWD_B_SEL);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
